// File: rtl/param_counter_if.sv
// Load/count request bus and status outputs for param_counter.
// The driver holds the master side; the counter is the slave.
interface param_counter_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] IN;
  logic             Load;
  logic             Up;
  logic             Down;
  logic             Enable;
  logic [WIDTH-1:0] Limit;
  logic [WIDTH-1:0] Counter;
  logic             High;
  logic             Low;
  logic             Ovf;
  logic             Unf;

  modport master (
    output IN, Load, Up, Down, Enable, Limit,
    input  Counter, High, Low, Ovf, Unf
  );

  modport slave (
    input  IN, Load, Up, Down, Enable, Limit,
    output Counter, High, Low, Ovf, Unf
  );
endinterface

// File: rtl/param_counter.sv
// Up/down counter with a programmable upper limit, saturate or wrap at
// the bounds, and one-cycle overflow/underflow pulses.
module param_counter #(
  parameter int WIDTH     = 5,
  parameter int STEP      = 1,
  parameter int WRAP_MODE = 0
) (
  input logic           CLK,
  input logic           RST,
  param_counter_if.slave bus
);

  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   lim_x;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH-1:0] dn_dif;
  logic [WIDTH-1:0] ld_val;
  logic             go_ld;
  logic             go_dn;
  logic             go_up;

  // Extended-width arithmetic so no bound test wraps at 2^WIDTH.
  assign cnt_x  = {1'b0, cnt_q};
  assign lim_x  = {1'b0, bus.Limit};
  assign up_sum = cnt_x + STEP_X;
  assign dn_dif = cnt_q - STEP_N;
  assign ld_val = (bus.IN > bus.Limit) ? bus.Limit : bus.IN;

  // Mutually exclusive actions: Load beats Down beats Up.
  assign go_ld = bus.Load;
  assign go_dn = !bus.Load && bus.Enable && bus.Down;
  assign go_up = !bus.Load && bus.Enable && bus.Up && !bus.Down;

  // Next count and event flags.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    unique case (1'b1)
      go_ld: cnt_d = ld_val;
      go_dn: begin
        if (cnt_x < STEP_X) begin
          unf_d = 1'b1;
          cnt_d = (WRAP_MODE != 0) ? bus.Limit : '0;
        end else begin
          cnt_d = dn_dif;
        end
      end
      go_up: begin
        if (up_sum > lim_x) begin
          ovf_d = 1'b1;
          cnt_d = (WRAP_MODE != 0) ? '0 : bus.Limit;
        end else begin
          cnt_d = up_sum[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  // State register; reset clears count and flags at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.Counter = cnt_q;
  assign bus.High    = (cnt_q >= bus.Limit);
  assign bus.Low     = (cnt_q == '0);
  assign bus.Ovf     = ovf_q;
  assign bus.Unf     = unf_q;

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter: two configurations driven in
// parallel, expectations queued per edge and checked by monitors.
module tb_param_counter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  param_counter_if #(.WIDTH(5)) ia ();
  param_counter_if #(.WIDTH(4)) ib ();

  param_counter #(.WIDTH(5), .STEP(1), .WRAP_MODE(0)) u_a (
    .CLK(clk), .RST(rst_n), .bus(ia.slave)
  );

  param_counter #(.WIDTH(4), .STEP(3), .WRAP_MODE(1)) u_b (
    .CLK(clk), .RST(rst_n), .bus(ib.slave)
  );

  typedef struct {
    int in_v; int lim; bit ld; bit up; bit dn; bit en;
  } stim_t;

  typedef struct {
    int cnt; bit ovf; bit unf; bit high; bit low;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ma = 0;
  int   mb = 0;
  int   la = 31;
  int   lb = 10;

  function automatic stim_t mk(int in_v, int lim,
                               bit ld, bit up, bit dn, bit en);
    stim_t s;
    s.in_v = in_v; s.lim = lim;
    s.ld = ld; s.up = up; s.dn = dn; s.en = en;
    return s;
  endfunction

  // Behavioural rules: next count after one edge.
  function automatic exp_t model(int step, bit wrap, int cnt, stim_t s);
    exp_t e;
    e.ovf = 0;
    e.unf = 0;
    e.cnt = cnt;
    if (s.ld) begin
      e.cnt = (s.in_v < s.lim) ? s.in_v : s.lim;
    end else if (s.en && s.dn) begin
      if (cnt - step < 0) begin
        e.unf = 1;
        e.cnt = wrap ? s.lim : 0;
      end else begin
        e.cnt = cnt - step;
      end
    end else if (s.en && s.up) begin
      if (cnt + step > s.lim) begin
        e.ovf = 1;
        e.cnt = wrap ? 0 : s.lim;
      end else begin
        e.cnt = cnt + step;
      end
    end
    e.high = (e.cnt >= s.lim);
    e.low  = (e.cnt == 0);
    return e;
  endfunction

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive_now(stim_t sa, stim_t sb);
    exp_t ea;
    exp_t eb;
    ia.IN = 5'(sa.in_v); ia.Limit = 5'(sa.lim);
    ia.Load = sa.ld; ia.Up = sa.up; ia.Down = sa.dn; ia.Enable = sa.en;
    ib.IN = 4'(sb.in_v); ib.Limit = 4'(sb.lim);
    ib.Load = sb.ld; ib.Up = sb.up; ib.Down = sb.dn; ib.Enable = sb.en;
    la = sa.lim;
    lb = sb.lim;
    ea = model(1, 1'b0, ma, sa);
    eb = model(3, 1'b1, mb, sb);
    ma = ea.cnt;
    mb = eb.cnt;
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  task automatic drive(stim_t sa, stim_t sb);
    @(negedge clk);
    drive_now(sa, sb);
  endtask

  task automatic check_reset_state();
    check("a_rst_cnt", int'(ia.Counter), 0);
    check("a_rst_ovf", int'(ia.Ovf), 0);
    check("a_rst_unf", int'(ia.Unf), 0);
    check("a_rst_low", int'(ia.Low), 1);
    check("a_rst_high", int'(ia.High), int'(la == 0));
    check("b_rst_cnt", int'(ib.Counter), 0);
    check("b_rst_ovf", int'(ib.Ovf), 0);
    check("b_rst_unf", int'(ib.Unf), 0);
    check("b_rst_low", int'(ib.Low), 1);
    check("b_rst_high", int'(ib.High), int'(lb == 0));
  endtask

  // Reset pulse between edges, then the next stimulus before the edge.
  task automatic mid_reset(stim_t sa, stim_t sb);
    @(negedge clk);
    rst_n = 1'b0;
    ma = 0;
    mb = 0;
    #1;
    check_reset_state();
    #1;
    rst_n = 1'b1;
    drive_now(sa, sb);
  endtask

  // Monitor for configuration A.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("a_cnt", int'(ia.Counter), e.cnt);
        check("a_ovf", int'(ia.Ovf), int'(e.ovf));
        check("a_unf", int'(ia.Unf), int'(e.unf));
        check("a_high", int'(ia.High), int'(e.high));
        check("a_low", int'(ia.Low), int'(e.low));
      end
    end
  end

  // Monitor for configuration B.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("b_cnt", int'(ib.Counter), e.cnt);
        check("b_ovf", int'(ib.Ovf), int'(e.ovf));
        check("b_unf", int'(ib.Unf), int'(e.unf));
        check("b_high", int'(ib.High), int'(e.high));
        check("b_low", int'(ib.Low), int'(e.low));
      end
    end
  end

  // Stimulus: reset, directed scenarios, then randomized traffic.
  initial begin
    stim_t ia_idle;
    stim_t sa;
    stim_t sb;
    rst_n = 1'b0;
    ia.IN = '0; ia.Limit = 5'd31;
    ia.Load = 0; ia.Up = 0; ia.Down = 0; ia.Enable = 0;
    ib.IN = '0; ib.Limit = 4'd10;
    ib.Load = 0; ib.Up = 0; ib.Down = 0; ib.Enable = 0;
    #3;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Load beats Down; Down beats Up; then Up alone.
    drive(mk(7, 31, 1, 0, 1, 1), mk(9, 10, 1, 0, 0, 0));
    drive(mk(7, 31, 0, 1, 1, 1), mk(0, 10, 0, 1, 0, 1));
    drive(mk(7, 31, 0, 1, 0, 1), mk(1, 10, 1, 0, 0, 0));
    drive(mk(7, 31, 1, 0, 0, 0), mk(0, 10, 0, 0, 1, 1));

    // Count up into saturation, then down into underflow.
    for (int i = 0; i < 26; i++)
      drive(mk(0, 31, 0, 1, 0, 1), mk(0, 10, 0, 1, 0, 1));
    for (int i = 0; i < 37; i++)
      drive(mk(0, 31, 0, 0, 1, 1), mk(0, 10, 0, 0, 1, 1));

    // Limit lowered under the count.
    drive(mk(20, 31, 1, 0, 0, 0), mk(12, 10, 1, 0, 0, 0));
    drive(mk(0, 5, 0, 0, 0, 1), mk(0, 4, 0, 0, 0, 1));
    #1;
    check("a_high_now", int'(ia.High), 1);
    check("b_high_now", int'(ib.High), 1);
    drive(mk(0, 5, 0, 1, 0, 1), mk(0, 4, 0, 1, 0, 1));

    // Enable low blocks counting; Load clamps to Limit.
    drive(mk(10, 31, 1, 0, 0, 0), mk(2, 15, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      drive(mk(0, 31, 0, 1, 0, 0), mk(0, 15, 0, 0, 1, 0));
    drive(mk(25, 20, 1, 1, 1, 0), mk(14, 13, 1, 0, 1, 1));

    // Limit of zero.
    for (int i = 0; i < 3; i++)
      drive(mk(0, 0, 0, 1, 0, 1), mk(0, 0, 0, 1, 0, 1));

    // Reset while counting up.
    drive(mk(12, 31, 1, 0, 0, 1), mk(5, 15, 1, 0, 0, 1));
    ia_idle = mk(0, 31, 0, 1, 0, 1);
    mid_reset(ia_idle, mk(0, 15, 0, 1, 0, 1));
    drive(ia_idle, mk(0, 15, 0, 1, 0, 1));

    // Randomized traffic with occasional limit moves and resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0)
        la = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0)
        lb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 15));
      sa = mk(int'($urandom_range(0, 31)), la,
              $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0, $urandom_range(0, 4) != 0);
      sb = mk(int'($urandom_range(0, 15)), lb,
              $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0, $urandom_range(0, 4) != 0);
      if ($urandom_range(0, 99) == 0)
        mid_reset(sa, sb);
      else
        drive(sa, sb);
    end

    @(negedge clk);
    @(negedge clk);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the counter and data width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter STEP, default 1, giving the per-cycle increment/decrement (1 <= STEP <= 2^WIDTH-1).
REQ-003 The block SHALL have parameter WRAP_MODE, default 0, selecting limit behaviour: 0 = saturate, 1 = wrap-around.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 IN  input  WIDTH  parallel load value.
REQ-007 Load  input  1  synchronous load request.
REQ-008 Up  input  1  count-up request.
REQ-009 Down  input  1  count-down request.
REQ-010 Enable  input  1  count enable; gates Up/Down only.
REQ-011 Limit  input  WIDTH  programmable upper bound, sampled every cycle.
REQ-012 Counter  output  WIDTH  registered count value.
REQ-013 High  output  1  combinational flag, 1 when Counter >= Limit.
REQ-014 Low  output  1  combinational flag, 1 when Counter == 0.
REQ-015 Ovf  output  1  registered one-cycle pulse: up-step overflowed Limit.
REQ-016 Unf  output  1  registered one-cycle pulse: down-step underflowed 0.

Function
REQ-017 Priority per rising edge SHALL be Load > Down > Up > hold; Load SHALL act regardless of Enable.
REQ-018 Load SHALL set Counter = min(IN, Limit) at the next edge; Ovf and Unf SHALL be 0 in the following cycle.
REQ-019 Up/Down SHALL act only when Enable = 1; with Enable = 0 and Load = 0, Counter SHALL hold and Ovf = Unf = 0.
REQ-020 Up/Down arithmetic SHALL be evaluated in WIDTH+1 bits; no intermediate result SHALL wrap at 2^WIDTH.
REQ-021 Up, Counter + STEP <= Limit: Counter SHALL become Counter + STEP, Ovf = 0.
REQ-022 Up, Counter + STEP > Limit: Ovf SHALL be 1 next cycle; Counter SHALL become Limit (WRAP_MODE = 0) or 0 (WRAP_MODE = 1).
REQ-023 Down, Counter >= STEP: Counter SHALL become Counter - STEP, Unf = 0.
REQ-024 Down, Counter < STEP: Unf SHALL be 1 next cycle; Counter SHALL become 0 (WRAP_MODE = 0) or Limit (WRAP_MODE = 1).
REQ-025 Ovf/Unf SHALL be asserted for exactly the cycle after each overflow/underflow edge; back-to-back events SHALL keep the flag high; Ovf and Unf SHALL never be 1 together.
REQ-026 A Limit change below the current Counter SHALL NOT alter Counter by itself; High SHALL assert in the same cycle, and the next Up SHALL follow REQ-022.
REQ-027 Limit = 0 SHALL be legal: High constantly 1; Up saturates/wraps to 0 with Ovf pulses.

Reset
REQ-028 RST = 0 SHALL immediately, without a clock edge, force Counter = 0, Ovf = 0, Unf = 0; hence Low = 1 and High = (Limit == 0).
REQ-029 RST = 0 SHALL override Load/Up/Down at any point, including mid-count; counting SHALL resume on the first rising edge after RST returns to 1.

Verification
REQ-030 WIDTH=5, STEP=1, WRAP_MODE=0, Limit=31: IN=7, Load=1, Down=1, one edge -> Counter=7; Load=0, Down=1, Up=1 -> Counter=6; Down=0 -> Counter=7.
REQ-031 Same config, Up=1 from 7 for 26 edges -> Counter=31, High=1, Ovf=1 after edges 25 and 26; Down for 37 edges -> Counter=0, Low=1, Unf pulses after final 6 edges.
REQ-032 WIDTH=4, STEP=3, WRAP_MODE=1, Limit=10: Load 9, Up -> Counter=0, Ovf=1 one cycle; Load 1, Down -> Counter=10, Unf=1 one cycle.
REQ-033 WRAP_MODE=0, Counter=20, Limit set to 5 -> High=1 same cycle, Counter=20; one Up edge -> Counter=5, Ovf=1.
REQ-034 Enable=0, Up=1 for 5 edges -> Counter unchanged, Ovf=0; Load with IN=25, Limit=20 -> Counter=20.
REQ-035 Counting up at Counter=12, RST pulsed low between edges -> Counter=0 before the next edge; after release, Up -> Counter=1.
